uart_tx_engine: RTL

Serial transmit stage directly downstream of the APB UART register block. Accepts bytes written by the register block into a small internal FIFO, then serialises them onto txd as start / 8 data (LSB first) / optional parity / 1 or 2 stop bits, with timing set by a programmable baud divisor. Reports FIFO occupancy and a per-frame completion pulse back to the register block for status and irqreq generation.

---
 rtl/uart_tx_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: small byte FIFO feeding a start/8N/parity/stop serialiser
// with a programmable per-bit divisor latched at the start of each frame.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic                         tx_en,
    input  logic                         parity_en,
    input  logic                         parity_odd,
    input  logic                         stop2,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    output logic                         wr_ready,
    output logic                         txd,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic               par_en_q;
    logic               stop2_q;
    logic [2:0]         bit_cnt;
    logic               stop_cnt;
    logic [7:0]         shift;
    logic               parity_q;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;

    logic               push;
    logic               pop;
    logic               bit_end;
    logic               last_stop;
    logic [7:0]         head;

    assign wr_ready   = (level < LVL_FULL);
    assign fifo_level = level;
    assign head       = mem[rd_ptr];
    assign push       = wr_valid && wr_ready;
    assign bit_end    = (cnt == div_q);
    assign last_stop  = !stop2_q || stop_cnt;

    // A new frame is fetched from IDLE or straight out of the final stop bit,
    // which is what makes back-to-back frames gapless.
    assign pop = tx_en && (level != '0) &&
                 ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Datapath storage carries no reset; it is always written before it is used.
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop) begin
            shift    <= head;
            parity_q <= (^head) ^ parity_odd;
        end else if (bit_end && ((state == START) || (state == DATA))) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            cnt      <= '0;
            div_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                state    <= START;
                txd      <= 1'b0;
                tx_busy  <= 1'b1;
                tx_done  <= (state == STOP);
                cnt      <= '0;
                div_q    <= baud_div;
                par_en_q <= parity_en;
                stop2_q  <= stop2;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt + CNT_ONE;
                end else begin
                    cnt <= '0;
                    case (state)
                        START: begin
                            state <= DATA;
                            txd   <= shift[0];
                        end
                        DATA: begin
                            if (bit_cnt == 3'd7) begin
                                state <= par_en_q ? PARITY : STOP;
                                txd   <= par_en_q ? parity_q : 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                txd     <= shift[0];
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
                        STOP: begin
                            if (!last_stop) begin
                                stop_cnt <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                                tx_done <= 1'b1;
                                txd     <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
